neuron_mac_unit: RTL and testbench

- Parametrised successor to the single-neuron datapath: streams N (input, weight) pairs over a valid/ready handshake, multiply-accumulates them and emits one activated result per vector.
- Adds generic data width, signed/unsigned mode, an internal controller FSM, output backpressure and optional bias.
- Sits between the input/weight memories and the next layer. Replaces the external ldIn/ldWeight/ldNReg/count_up sequencing.

---
 rtl/neuron_pkg.sv | 25 ++
 rtl/neuron_act.sv | 18 +
 rtl/neuron_mac_unit.sv | 149 ++++++++++++++
 tb/tb_neuron_mac_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and sizing helpers for the neuron MAC unit.
// Accumulator width and controller state encoding live here.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Wide enough for N full-scale products plus a bias term.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// Output activation: ReLU for signed operands, pass-through for unsigned.
module neuron_act #(
    parameter int ACC_W  = 19,
    parameter bit SIGNED = 1'b1
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] act
);

    generate
        if (SIGNED) begin : g_relu
            assign act = acc[ACC_W-1] ? '0 : acc;
        end else begin : g_pass
            assign act = acc;
        end
    endgenerate

endmodule

// File: rtl/neuron_mac_unit.sv
// Streaming N-pair multiply-accumulate neuron with activation output.
// Optional bias input enabled by defining NEURON_BIAS_EN.
module neuron_mac_unit
    import neuron_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter bit SIGNED = 1'b1,
    localparam int ACC_W = acc_width(DATA_W, N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
`ifdef NEURON_BIAS_EN
    input  logic [2*DATA_W-1:0] in_bias,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);

    localparam int CNT_W = (N > 1) ? clog2(N) : 1;
    localparam int PW    = 2 * DATA_W;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_r, w_r;
    logic              first_r, v1;
    logic [ACC_W-1:0]  acc, acc_nxt, base, prod_ext, act_w, out_r;
    logic [PW-1:0]     a_ext, w_ext, prod;
    logic              accept, last;
    logic              sa, sw, sp;

    assign in_ready = (state == ST_ACC);
    assign accept   = in_valid && (state == ST_ACC);
    assign last     = (cnt == CNT_W'(N - 1));
    assign busy     = (state != ST_ACC) || (cnt != '0);
    assign out_data = out_r;

    // Low half of a 2W x 2W product equals the W x W product in either mode.
    assign sa    = SIGNED && a_r[DATA_W-1];
    assign sw    = SIGNED && w_r[DATA_W-1];
    assign a_ext = {{DATA_W{sa}}, a_r};
    assign w_ext = {{DATA_W{sw}}, w_r};
    assign prod  = a_ext * w_ext;

    assign sp       = SIGNED && prod[PW-1];
    assign prod_ext = {{(ACC_W - PW){sp}}, prod};

`ifdef NEURON_BIAS_EN
    logic [PW-1:0]    bias_r;
    logic             sb;
    logic [ACC_W-1:0] bias_ext;

    assign sb       = SIGNED && bias_r[PW-1];
    assign bias_ext = {{(ACC_W - PW){sb}}, bias_r};
    assign base     = first_r ? bias_ext : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_r <= '0;
        end else if (accept && (cnt == '0)) begin
            bias_r <= in_bias;
        end
    end
`else
    assign base = first_r ? '0 : acc;
`endif

    assign acc_nxt = base + prod_ext;

    neuron_act #(
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_act (
        .acc (acc_nxt),
        .act (act_w)
    );

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        unique case (state)
            ST_ACC: begin
                if (accept && last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_ACC;
            end
            default: begin
                state_nxt = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            a_r     <= '0;
            w_r     <= '0;
            first_r <= 1'b0;
            v1      <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a_r     <= in_data;
                w_r     <= in_weight;
                first_r <= (cnt == '0);
                cnt     <= last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (v1) begin
            acc <= acc_nxt;
        end
    end

    // The final product is still in flight during DRAIN, so latch the
    // activated next-accumulator value rather than acc itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= '0;
        end else if (state == ST_DRAIN) begin
            out_r <= act_w;
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Bench for neuron_mac_unit: three configurations checked against a
// transaction-level model plus directed literal expectations.
module tb_neuron_mac_unit;

    localparam int NK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       in_valid [NK];
    logic       out_ready[NK];
    logic [7:0] in_data  [NK];
    logic [7:0] in_weight[NK];
    logic       in_ready [NK];
    logic       out_valid[NK];
    logic       busy     [NK];
    logic [18:0] od0, od1;
    logic [16:0] od2;
`ifdef NEURON_BIAS_EN
    logic [15:0] in_bias[NK];
`endif

    neuron_mac_unit #(.DATA_W(8), .N(4), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_weight(in_weight[0]),
`ifdef NEURON_BIAS_EN
        .in_bias(in_bias[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od0), .busy(busy[0])
    );

    neuron_mac_unit #(.DATA_W(8), .N(4), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_weight(in_weight[1]),
`ifdef NEURON_BIAS_EN
        .in_bias(in_bias[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od1), .busy(busy[1])
    );

    neuron_mac_unit #(.DATA_W(8), .N(1), .SIGNED(1'b1)) u_n1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_weight(in_weight[2]),
`ifdef NEURON_BIAS_EN
        .in_bias(in_bias[2]),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od2), .busy(busy[2])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int done_cnt = 0;

    const int nn[NK] = '{4, 4, 1};
    const bit sg[NK] = '{1'b0, 1'b1, 1'b1};

    // model: running sum, pairs seen, result pending, cycles since last pair
    int m_sum  [NK];
    int m_cnt  [NK];
    int m_res  [NK];
    int m_since[NK];
    bit m_hold [NK];

    function automatic int od(input int k);
        case (k)
            0:       return int'(od0);
            1:       return int'(od1);
            default: return int'(od2);
        endcase
    endfunction

    function automatic int opv(input int k, input logic [7:0] v);
        return sg[k] ? int'($signed(v)) : int'(v);
    endfunction

    function automatic int biasv(input int k);
`ifdef NEURON_BIAS_EN
        return sg[k] ? int'($signed(in_bias[k])) : int'(in_bias[k]);
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NK; k++) begin
                if (!rst) begin
                    chk("rst_valid", k, int'(out_valid[k]), 0);
                    chk("rst_busy", k, int'(busy[k]), 0);
                    chk("rst_ready", k, int'(in_ready[k]), 1);
                    chk("rst_data", k, od(k), 0);
                    m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_since[k] = 0;
                end else begin
                    bit ev;
                    ev = m_hold[k] && (m_since[k] >= 1);
                    chk("ready", k, int'(in_ready[k]), int'(!m_hold[k]));
                    chk("valid", k, int'(out_valid[k]), int'(ev));
                    chk("busy", k, int'(busy[k]), int'(m_hold[k] || m_cnt[k] != 0));
                    if (ev) chk("data", k, od(k), m_res[k]);
                    if (m_hold[k]) begin
                        if (ev && out_ready[k]) m_hold[k] = 0;
                        else m_since[k]++;
                    end else if (in_valid[k]) begin
                        if (m_cnt[k] == 0) m_sum[k] = biasv(k);
                        m_sum[k] += opv(k, in_data[k]) * opv(k, in_weight[k]);
                        m_cnt[k]++;
                        if (m_cnt[k] == nn[k]) begin
                            m_cnt[k]   = 0;
                            m_hold[k]  = 1;
                            m_since[k] = 0;
                            m_res[k]   = (sg[k] && m_sum[k] < 0) ? 0 : m_sum[k];
                        end
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send(input int k, input int a, input int w, input int gap);
        logic [7:0] av, wv;
        av = a[7:0];
        wv = w[7:0];
        repeat (gap) begin
            in_valid[k] = 1'b0;
            @(posedge clk); #1;
        end
        in_valid[k]  = 1'b1;
        in_data[k]   = av;
        in_weight[k] = wv;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1", k);
        in_valid[k] = 1'b0;
    endtask

    task automatic run_vec(input int k, input int a[4], input int w[4],
                           input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            send(k, a[i], w[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        in_valid[k] = 1'b0;
    endtask

    // Ends at the negedge where out_valid is seen; lat counts cycles.
    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            lat++;
            if (out_valid[k]) return;
        end
        total++; bad++;
        $display("FAIL out_timeout dut%0d: out_valid stayed 0, required 1", k);
    endtask

    task automatic expect_res(input string nm, input int k, input int exp, input int lat_exp);
        int lat;
        wait_valid(k, lat);
        chk({nm, "_data"}, k, od(k), exp);
        chk({nm, "_lat"}, k, lat, lat_exp);
        @(posedge clk); #1;
    endtask

    task automatic rand_run(input int k, input int nvec);
        int va[4], vw[4];
        for (int v = 0; v < nvec; v++) begin
`ifdef NEURON_BIAS_EN
            in_bias[k] = 16'($urandom_range(0, 65535));
`endif
            for (int i = 0; i < 4; i++) begin
                va[i] = $urandom_range(0, 255);
                vw[i] = $urandom_range(0, 255);
            end
            run_vec(k, va, vw, nn[k], 3);
        end
        done_cnt++;
    endtask

    initial begin
        int va[4], vw[4];
        int acc_cnt;
        for (int k = 0; k < NK; k++) begin
            in_valid[k] = 0; out_ready[k] = 1; in_data[k] = 0; in_weight[k] = 0;
`ifdef NEURON_BIAS_EN
            in_bias[k] = 0;
`endif
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("t1_rst_ready", 0, int'(in_ready[0]), 1);
        chk("t1_rst_valid", 0, int'(out_valid[0]), 0);
        chk("t1_rst_data", 0, od(0), 0);

        // unsigned dot product back-to-back
        va = '{1, 3, 5, 7}; vw = '{2, 4, 6, 8};
        run_vec(0, va, vw, 4, 0);
        expect_res("t1_dot", 0, 100, 2);

        // signed ReLU clamp, then full-scale positive
        va = '{-128, 1, 0, 2}; vw = '{127, 1, 5, -3};
        run_vec(1, va, vw, 4, 0);
        expect_res("t2_relu", 1, 0, 2);
        va = '{-128, -128, -128, -128}; vw = va;
        run_vec(1, va, vw, 4, 0);
        expect_res("t2_max", 1, 65536, 2);

        // backpressure with input gaps
        out_ready[0] = 1'b0;
        va = '{1, 3, 5, 7}; vw = '{2, 4, 6, 8};
        run_vec(0, va, vw, 4, 3);
        begin
            int lat;
            wait_valid(0, lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t3_hold_ready", 0, int'(in_ready[0]), 0);
            chk("t3_hold_valid", 0, int'(out_valid[0]), 1);
            chk("t3_hold_data", 0, od(0), 100);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_drop_valid", 0, int'(out_valid[0]), 0);
        @(posedge clk); #1;

        // async reset mid-vector
        send(0, 9, 9, 0);
        send(0, 9, 9, 0);
        in_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t4_clr_busy", 0, int'(busy[0]), 0);
        chk("t4_clr_valid", 0, int'(out_valid[0]), 0);
        chk("t4_clr_data", 0, od(0), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        va = '{1, 1, 1, 1}; vw = va;
        run_vec(0, va, vw, 4, 0);
        expect_res("t4_after", 0, 4, 2);

        // N=1 single pair and minimum period
        send(2, 9, 9, 0);
        in_valid[2] = 1'b0;
        expect_res("t5_n1", 2, 81, 2);
        in_valid[2] = 1'b1; in_data[2] = 8'd3; in_weight[2] = 8'd5;
        acc_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (in_ready[2]) acc_cnt++;
            @(posedge clk); #1;
        end
        in_valid[2] = 1'b0;
        chk("t5_period", 2, acc_cnt, 10);
        repeat (4) @(posedge clk);
        #1;

`ifdef NEURON_BIAS_EN
        in_bias[1] = -16'sd50;
        va = '{1, 1, 1, 1}; vw = '{10, 10, 10, 10};
        run_vec(1, va, vw, 4, 0);
        expect_res("t6_negbias", 1, 0, 2);
        in_bias[1] = 16'sd10;
        run_vec(1, va, vw, 4, 0);
        expect_res("t6_posbias", 1, 50, 2);
        send(1, 1, 10, 0);
        in_bias[1] = 16'sd100;
        for (int i = 0; i < 3; i++) send(1, 1, 10, 0);
        in_valid[1] = 1'b0;
        expect_res("t6_late", 1, 50, 2);
`endif

        // randomized traffic with random output backpressure
        fork
            rand_run(0, 20);
            rand_run(1, 20);
            rand_run(2, 40);
            begin
                while (done_cnt < 3) begin
                    @(posedge clk); #1;
                    for (int k = 0; k < NK; k++) out_ready[k] = ($urandom_range(0, 1) == 1);
                end
                for (int k = 0; k < NK; k++) out_ready[k] = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) chk("final_idle", k, int'(busy[k]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
